// File: rtl/stopwatch_if.sv
// Panel-side signal bundle for the stopwatch controller: raw buttons, live time in,
// commands, display time and status out.
interface stopwatch_if #(
    parameter int LAP_W = 4
);
    logic             btn_ss;
    logic             btn_lap;
    logic [5:0]       sw_seconds;
    logic [5:0]       sw_minutes;
    logic             sw_start;
    logic             sw_stop;
    logic             sw_reset;
    logic [5:0]       disp_seconds;
    logic [5:0]       disp_minutes;
    logic [LAP_W-1:0] lap_count;
    logic [1:0]       state;

    modport master (
        input  btn_ss, btn_lap, sw_seconds, sw_minutes,
        output sw_start, sw_stop, sw_reset, disp_seconds, disp_minutes, lap_count, state
    );

    modport slave (
        output btn_ss, btn_lap, sw_seconds, sw_minutes,
        input  sw_start, sw_stop, sw_reset, disp_seconds, disp_minutes, lap_count, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: button sync/debounce, run/pause/lap sequencing,
// single-cycle stopwatch commands, lap capture and display source selection.
//
//   state    | meaning
//   IDLE     | cleared, waiting for start
//   RUNNING  | stopwatch counting, display follows live time
//   PAUSED   | stopwatch stopped, lap button clears
//   LAP_HOLD | stopwatch counting, display frozen on last lap
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_W            = 8,
    parameter int LAP_W           = 4
) (
    input logic        clk,
    input logic        reset,
    stopwatch_if.master bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUNNING  = 2'b01,
        PAUSED   = 2'b10,
        LAP_HOLD = 2'b11
    } state_t;

    state_t state_q, state_d;

    // bit 0 = start/stop button, bit 1 = lap/reset button
    logic [1:0]      raw;
    logic [1:0]      sync1, sync2;
    logic [1:0]      deb, deb_d;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;
    logic            ev_ss, ev_lap;

    logic             start_q, stop_q, clr_q;
    logic             start_d, stop_d, clr_d;
    logic             capture, clear_laps;
    logic [5:0]       live_sec, live_min;
    logic [5:0]       lap_sec, lap_min;
    logic [LAP_W-1:0] lap_cnt;

    assign raw    = {bus.btn_lap, bus.btn_ss};
    assign press  = deb & ~deb_d;
    assign ev_ss  = press[0];
    assign ev_lap = press[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // start/stop has priority; a lap event in the same cycle is dropped
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        clr_d      = 1'b0;
        capture    = 1'b0;
        clear_laps = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev_ss) begin
                    start_d = 1'b1;
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                if (ev_ss) begin
                    stop_d  = 1'b1;
                    state_d = PAUSED;
                end else if (ev_lap) begin
                    capture = 1'b1;
                    state_d = LAP_HOLD;
                end
            end
            LAP_HOLD: begin
                if (ev_ss) begin
                    stop_d  = 1'b1;
                    state_d = PAUSED;
                end else if (ev_lap) begin
                    state_d = RUNNING;
                end
            end
            PAUSED: begin
                if (ev_ss) begin
                    start_d = 1'b1;
                    state_d = RUNNING;
                end else if (ev_lap) begin
                    clr_d      = 1'b1;
                    clear_laps = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            clr_q    <= 1'b0;
            live_sec <= '0;
            live_min <= '0;
            lap_sec  <= '0;
            lap_min  <= '0;
            lap_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            clr_q    <= clr_d;
            live_sec <= bus.sw_seconds;
            live_min <= bus.sw_minutes;
            if (clear_laps) begin
                lap_sec <= '0;
                lap_min <= '0;
                lap_cnt <= '0;
            end else if (capture) begin
                lap_sec <= bus.sw_seconds;
                lap_min <= bus.sw_minutes;
                if (lap_cnt != '1) begin
                    lap_cnt <= lap_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.sw_start     = start_q;
    assign bus.sw_stop      = stop_q;
    assign bus.sw_reset     = clr_q;
    assign bus.state        = state_q;
    assign bus.lap_count    = lap_cnt;
    assign bus.disp_seconds = (state_q == LAP_HOLD) ? lap_sec : live_sec;
    assign bus.disp_minutes = (state_q == LAP_HOLD) ? lap_min : live_min;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed panel sequences followed by random
// button traffic, all compared every cycle against a behavioural panel model.
module tb_stopwatch_ctrl;
    localparam int DB    = 4;
    localparam int LW    = 4;
    localparam int LAPMX = (1 << LW) - 1;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_HOLD = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stopwatch_if #(.LAP_W(LW)) bus();

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB), .DB_W(8), .LAP_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: raw samples per edge (newest first), debounced levels after the last two edges
    bit hist_ss[$];
    bit hist_lap[$];
    bit deb_ss, debp_ss, deb_lap, debp_lap;
    int m_state;
    bit m_start, m_stop, m_rst;
    int m_lap_cnt, m_lap_s, m_lap_m, m_live_s, m_live_m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // A level is accepted once the synchronised samples (raw delayed two edges) have
    // disagreed with the current level for DB consecutive edges.
    function automatic bit settle(input bit q[$], input bit cur);
        bit all_opp = 1'b1;
        for (int j = 2; j <= DB + 1; j++) begin
            if (q[j] == cur) all_opp = 1'b0;
        end
        return all_opp ? ~cur : cur;
    endfunction

    task automatic model_step(input bit r, input bit ss, input bit lap, input int s, input int m);
        bit ev_ss, ev_lap, n_ss, n_lap;
        if (r) begin
            hist_ss.delete();
            hist_lap.delete();
            for (int j = 0; j < DB + 2; j++) begin
                hist_ss.push_back(1'b0);
                hist_lap.push_back(1'b0);
            end
            {deb_ss, debp_ss, deb_lap, debp_lap} = '0;
            m_state = S_IDLE;
            {m_start, m_stop, m_rst} = '0;
            m_lap_cnt = 0; m_lap_s = 0; m_lap_m = 0; m_live_s = 0; m_live_m = 0;
            return;
        end
        ev_ss  = deb_ss & ~debp_ss;
        ev_lap = deb_lap & ~debp_lap;
        {m_start, m_stop, m_rst} = '0;
        if (ev_ss) begin
            if (m_state == S_IDLE || m_state == S_PAUSE) begin
                m_start = 1'b1; m_state = S_RUN;
            end else begin
                m_stop = 1'b1; m_state = S_PAUSE;
            end
        end else if (ev_lap) begin
            if (m_state == S_RUN) begin
                m_lap_s = s; m_lap_m = m;
                if (m_lap_cnt < LAPMX) m_lap_cnt++;
                m_state = S_HOLD;
            end else if (m_state == S_HOLD) begin
                m_state = S_RUN;
            end else if (m_state == S_PAUSE) begin
                m_rst = 1'b1; m_lap_cnt = 0; m_lap_s = 0; m_lap_m = 0; m_state = S_IDLE;
            end
        end
        m_live_s = s;
        m_live_m = m;
        hist_ss.push_front(ss);   void'(hist_ss.pop_back());
        hist_lap.push_front(lap); void'(hist_lap.pop_back());
        n_ss  = settle(hist_ss, deb_ss);
        n_lap = settle(hist_lap, deb_lap);
        debp_ss = deb_ss;   deb_ss = n_ss;
        debp_lap = deb_lap; deb_lap = n_lap;
    endtask

    task automatic compare_all();
        check_eq("state", bus.state, m_state);
        check_eq("sw_start", bus.sw_start, m_start);
        check_eq("sw_stop", bus.sw_stop, m_stop);
        check_eq("sw_reset", bus.sw_reset, m_rst);
        check_eq("lap_count", bus.lap_count, m_lap_cnt);
        check_eq("disp_seconds", bus.disp_seconds, (m_state == S_HOLD) ? m_lap_s : m_live_s);
        check_eq("disp_minutes", bus.disp_minutes, (m_state == S_HOLD) ? m_lap_m : m_live_m);
        check_eq("cmd_onehot", ($countones({bus.sw_start, bus.sw_stop, bus.sw_reset}) <= 1), 1);
    endtask

    task automatic cycle(input bit r, input bit ss, input bit lap);
        int s, m;
        @(negedge clk);
        compare_all();
        s = $urandom_range(0, 59);
        m = $urandom_range(0, 59);
        reset          = r;
        bus.btn_ss     = ss;
        bus.btn_lap    = lap;
        bus.sw_seconds = 6'(s);
        bus.sw_minutes = 6'(m);
        model_step(r, ss, lap, s, m);
    endtask

    task automatic hold(input bit ss, input bit lap, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, ss, lap);
    endtask

    initial begin
        int len, rnd;
        bit ss, lap, r;
        reset          = 1'b1;
        bus.btn_ss     = 1'b0;
        bus.btn_lap    = 1'b0;
        bus.sw_seconds = '0;
        bus.sw_minutes = '0;
        model_step(1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);

        // short glitches never reach the debounced level
        hold(1'b1, 1'b0, 1); hold(1'b0, 1'b0, 8);
        hold(1'b1, 1'b0, 2); hold(1'b0, 1'b0, 8);
        hold(1'b1, 1'b0, 3); hold(1'b0, 1'b0, 8);
        @(negedge clk);
        check_eq("glitch_state", bus.state, S_IDLE);

        hold(1'b1, 1'b0, 10); hold(1'b0, 1'b0, 10);
        @(negedge clk);
        check_eq("start_state", bus.state, S_RUN);

        hold(1'b0, 1'b1, 10); hold(1'b0, 1'b0, 10);
        @(negedge clk);
        check_eq("hold_state", bus.state, S_HOLD);
        hold(1'b0, 1'b1, 10); hold(1'b0, 1'b0, 10);

        // 20 captures from RUNNING with a pause/resume round trip in the middle
        for (int i = 0; i < 40; i++) begin
            hold(1'b0, 1'b1, 8); hold(1'b0, 1'b0, 8);
            if (i == 19) begin
                hold(1'b1, 1'b0, 8); hold(1'b0, 1'b0, 8);
                hold(1'b1, 1'b0, 8); hold(1'b0, 1'b0, 8);
            end
        end
        @(negedge clk);
        check_eq("lap_saturate", bus.lap_count, LAPMX);

        // simultaneous presses: start/stop wins
        hold(1'b1, 1'b1, 10); hold(1'b0, 1'b0, 10);
        @(negedge clk);
        check_eq("simul_state", bus.state, S_PAUSE);
        hold(1'b0, 1'b1, 10); hold(1'b0, 1'b0, 10);
        hold(1'b0, 1'b1, 10); hold(1'b0, 1'b0, 10);
        @(negedge clk);
        check_eq("clear_state", bus.state, S_IDLE);

        // reset in the middle of a debounce window
        hold(1'b1, 1'b0, 5);
        cycle(1'b1, 1'b1, 1'b0);
        hold(1'b0, 1'b0, 12);

        for (int seg = 0; seg < 2500; seg++) begin
            len = $urandom_range(1, 14);
            rnd = $urandom_range(0, 3);
            ss  = 1'($urandom_range(0, 1));
            lap = (rnd == 0) ? ss : 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < len; i++) cycle(r && (i == 0), ss, lap);
        end
        @(negedge clk);
        compare_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-panel controller that sequences the stopwatch counter block from two raw push-buttons (start/stop and lap/reset). It synchronises and debounces both buttons, runs the IDLE/RUNNING/PAUSED/LAP_HOLD state machine, and issues single-cycle start/stop/reset commands to the stopwatch. It also captures lap times and selects live or frozen time for the display path.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synced-sample cycles required before a debounced level changes (1..2^DB_W-1)
DB_W, 8, width of each debounce counter
LAP_W, 4, width of lap_count (saturates at 2^LAP_W-1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
btn_ss  input  1  raw start/stop button, asynchronous, active-high
btn_lap  input  1  raw lap/reset button, asynchronous, active-high
sw_seconds  input  6  live seconds from the stopwatch counter (0..59)
sw_minutes  input  6  live minutes from the stopwatch counter (0..59)
sw_start  output  1  one-cycle start command to the stopwatch
sw_stop  output  1  one-cycle stop command to the stopwatch
sw_reset  output  1  one-cycle clear command to the stopwatch
disp_seconds  output  6  seconds for the display
disp_minutes  output  6  minutes for the display
lap_count  output  LAP_W  number of laps captured since last clear
state  output  2  FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 LAP_HOLD

Behaviour:
- Reset (synchronous): state=IDLE; sw_start/sw_stop/sw_reset=0; disp_*=0; lap_count=0; lap registers=0; sync flops, debounced levels and debounce counters=0.
- Per button: 2-flop synchroniser, then debouncer. If synced != debounced level, counter increments; when counter reaches DEBOUNCE_CYCLES, debounced level takes synced value and counter clears. If synced == debounced level, counter clears. Any mismatch glitch shorter than DEBOUNCE_CYCLES produces no change.
- Press event: one-cycle pulse on debounced 0->1 edge only. Release generates nothing. Holding a button yields exactly one event.
- A button held high through reset release is seen as a new press after sync plus DEBOUNCE_CYCLES.
- Latency: press event in cycle N -> state and sw_* command registered at N+1. Commands are high exactly one cycle.
- Transitions (ss = start/stop event, lap = lap/reset event):
  IDLE: ss -> sw_start, RUNNING. lap ignored.
  RUNNING: ss -> sw_stop, PAUSED. lap -> capture sw_minutes/sw_seconds into lap regs, lap_count+1, LAP_HOLD.
  LAP_HOLD: ss -> sw_stop, PAUSED. lap -> release hold, RUNNING, no capture. Stopwatch keeps counting throughout.
  PAUSED: ss -> sw_start, RUNNING. lap -> sw_reset, lap_count=0, lap regs=0, IDLE.
- Simultaneous ss and lap events in one cycle: ss acts, lap is discarded, not queued.
- lap_count saturates at 2^LAP_W-1. Captures still update the lap regs at saturation.
- Display: in LAP_HOLD, disp_* = lap regs. In all other states, disp_* = sw_* registered, 1-cycle delay.
- Capture samples the sw_* value present in the event cycle N.
- No command is ever issued in a state where it is not listed above. At most one of sw_start/sw_stop/sw_reset is high in any cycle.
- Reset asserted mid-operation, including mid-debounce or with a command pulse high: the next cycle shows reset values and pending events are lost.

Test Plan:
1. Reset, then btn_ss high for 10 cycles (DEBOUNCE_CYCLES=4) -> exactly one sw_start pulse, 1+2+4+1 cycles after the raw rise (±1 per the sync boundary); state 00->01; no pulse on release.
2. btn_ss glitches of 1, 2 and 3 cycles -> no debounced change, no command, state stays 00.
3. RUNNING with sw_minutes=2, sw_seconds=17; lap press -> state 11, disp 2:17 held while sw_* advance to 2:20, lap_count=1. Second lap press -> state 01, disp follows live with 1-cycle lag.
4. RUNNING -> ss -> sw_stop, state 10. Then lap -> sw_reset one cycle, lap_count=0, state 00. Then lap again in IDLE -> no command.
5. Both buttons debounced to press in the same cycle while RUNNING -> only sw_stop, state 10, lap_count unchanged.
6. 16 lap captures with LAP_W=4 (alternating RUNNING/LAP_HOLD cycles plus an ss/ss pause round trip) -> lap_count saturates at 15. Assert reset mid-debounce -> all outputs 0, state 00 the next cycle.
